cachepool_l2_chan_sched: RTL and testbench

- Schedules memory requests from the cluster AXI masters (Snitch core port plus one per L1 cache controller, 5 total) onto the 4 L2/DRAM channels.
- Each request's address selects its target channel through the interleave bits. Each channel runs an independent round-robin arbiter, a single-entry output register and an outstanding-transaction limiter.
- Sits between the cluster master ports and the per-channel L2 AXI crossbar/DRAM controller front ends.

---
 rtl/cachepool_l2_chan_sched.sv | 143 ++++++++++++++
 tb/tb_cachepool_l2_chan_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cachepool_l2_chan_sched.sv
// Schedules requests from the cluster AXI masters onto the interleaved L2
// channels. Each channel has its own round-robin arbiter, a single-entry
// output register and an in-flight transaction limiter.
module cachepool_l2_chan_sched #(
  parameter int unsigned NumReq         = 5,
  parameter int unsigned NumChannel     = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 6,
  parameter int unsigned ChanOffset     = 10,
  parameter int unsigned MaxOutstanding = 32,
  parameter int unsigned SrcBits        = $clog2(NumReq)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NumReq-1:0]                        req_valid_i,
  output logic [NumReq-1:0]                        req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]              req_addr_i,
  input  logic [NumReq*IdWidth-1:0]                req_id_i,
  input  logic [NumReq-1:0]                        req_write_i,
  output logic [NumChannel-1:0]                    chan_valid_o,
  input  logic [NumChannel-1:0]                    chan_ready_i,
  output logic [NumChannel*AddrWidth-1:0]          chan_addr_o,
  output logic [NumChannel*(SrcBits+IdWidth)-1:0]  chan_id_o,
  output logic [NumChannel-1:0]                    chan_write_o,
  input  logic [NumChannel-1:0]                    cpl_valid_i,
  output logic [NumChannel*6-1:0]                  outstanding_o,
  output logic                                     busy_o
);

  localparam int unsigned ChanBits = $clog2(NumChannel);
  localparam int unsigned CntW     = 6;
  localparam int unsigned OutIdW   = SrcBits + IdWidth;

  logic [ChanBits-1:0]  req_chan   [NumReq];
  logic [SrcBits-1:0]   rr_ptr     [NumChannel];
  logic [CntW-1:0]      cnt        [NumChannel];
  logic [NumChannel-1:0] can_accept;
  logic [NumChannel-1:0] gnt_any;
  logic [SrcBits-1:0]   gnt_idx    [NumChannel];
  logic [NumReq-1:0]    gnt_req;
  logic [NumChannel-1:0] out_valid;
  logic [AddrWidth-1:0] out_addr   [NumChannel];
  logic [OutIdW-1:0]    out_id     [NumChannel];
  logic [NumChannel-1:0] out_write;

  // Target channel of each requester from the interleave bits
  always_comb begin
    for (int unsigned r = 0; r < NumReq; r++) begin
      req_chan[r] = req_addr_i[r*AddrWidth+ChanOffset +: ChanBits];
    end
  end

  // Channel can take a new request: slot free/draining and budget available
  always_comb begin
    can_accept = '0;
    for (int unsigned c = 0; c < NumChannel; c++) begin
      can_accept[c] = (!out_valid[c] || chan_ready_i[c]) &&
                      ((cnt[c] < CntW'(MaxOutstanding)) ||
                       ((cnt[c] == CntW'(MaxOutstanding)) && cpl_valid_i[c]));
    end
  end

  // Per-channel round-robin search starting at the pointer, wrapping mod NumReq.
  // A requester targets exactly one channel, so it can win at most one grant.
  always_comb begin
    int unsigned idx_wide;
    logic [SrcBits-1:0] idx;
    idx_wide = 0;
    idx      = '0;
    gnt_any  = '0;
    gnt_req  = '0;
    for (int unsigned c = 0; c < NumChannel; c++) begin
      gnt_idx[c] = '0;
    end
    for (int unsigned c = 0; c < NumChannel; c++) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        idx_wide = 32'(rr_ptr[c]) + k;
        if (idx_wide >= NumReq) idx_wide = idx_wide - NumReq;
        idx = SrcBits'(idx_wide);
        if (can_accept[c] && !gnt_any[c] && req_valid_i[idx] &&
            (req_chan[idx] == ChanBits'(c))) begin
          gnt_any[c]   = 1'b1;
          gnt_idx[c]   = idx;
          gnt_req[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = rst_ni ? gnt_req : '0;

  // Output register, RR pointer and outstanding counter per channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChannel; c++) begin
        out_valid[c] <= 1'b0;
        out_addr[c]  <= '0;
        out_id[c]    <= '0;
        out_write[c] <= 1'b0;
        rr_ptr[c]    <= '0;
        cnt[c]       <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NumChannel; c++) begin
        if (gnt_any[c]) begin
          out_valid[c] <= 1'b1;
          out_addr[c]  <= req_addr_i[gnt_idx[c]*AddrWidth +: AddrWidth];
          out_id[c]    <= {gnt_idx[c], req_id_i[gnt_idx[c]*IdWidth +: IdWidth]};
          out_write[c] <= req_write_i[gnt_idx[c]];
          rr_ptr[c]    <= (gnt_idx[c] == SrcBits'(NumReq - 1)) ? '0
                                                               : gnt_idx[c] + SrcBits'(1);
        end else if (chan_ready_i[c]) begin
          out_valid[c] <= 1'b0;
        end
        // A completion at zero is spurious and ignored, so it never cancels a grant
        if (gnt_any[c] && !(cpl_valid_i[c] && (cnt[c] != '0))) begin
          cnt[c] <= cnt[c] + CntW'(1);
        end else if (!gnt_any[c] && cpl_valid_i[c] && (cnt[c] != '0)) begin
          cnt[c] <= cnt[c] - CntW'(1);
        end
      end
    end
  end

  // Flatten per-channel state onto the packed ports
  always_comb begin
    busy_o = 1'b0;
    for (int unsigned c = 0; c < NumChannel; c++) begin
      chan_valid_o[c]                        = out_valid[c];
      chan_addr_o[c*AddrWidth +: AddrWidth]  = out_addr[c];
      chan_id_o[c*OutIdW +: OutIdW]          = out_id[c];
      chan_write_o[c]                        = out_write[c];
      outstanding_o[c*CntW +: CntW]          = cnt[c];
      busy_o = busy_o | out_valid[c] | (cnt[c] != '0);
    end
  end

  for (genvar g = 0; g < NumChannel; g++) begin : g_cpl_chk
    a_cpl_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cpl_valid_i[g] |-> (cnt[g] != '0));
  end

endmodule

// File: tb/tb_cachepool_l2_chan_sched.sv
// Bench for cachepool_l2_chan_sched: directed scenarios plus random traffic,
// checked every cycle against a behavioural channel model.
module tb_cachepool_l2_chan_sched;
  localparam int NR = 5;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int OW = 9;
  localparam int MAXO = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NR-1:0]    req_valid_i, req_ready_o, req_write_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*IW-1:0] req_id_i;
  logic [NC-1:0]    chan_valid_o, chan_ready_i, chan_write_o, cpl_valid_i;
  logic [NC*AW-1:0] chan_addr_o;
  logic [NC*OW-1:0] chan_id_o;
  logic [NC*6-1:0]  outstanding_o;
  logic             busy_o;

  logic [31:0] a_req [NR];
  logic [5:0]  id_req[NR];

  int n_checks = 0;
  int n_errors = 0;

  always_comb begin
    req_addr_i = '0;
    req_id_i   = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW] = a_req[i];
      req_id_i[i*IW +: IW]   = id_req[i];
    end
  end

  cachepool_l2_chan_sched #(
    .NumReq(NR), .NumChannel(NC), .AddrWidth(AW), .IdWidth(IW),
    .ChanOffset(10), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_id_i(req_id_i), .req_write_i(req_write_i),
    .chan_valid_o(chan_valid_o), .chan_ready_i(chan_ready_i),
    .chan_addr_o(chan_addr_o), .chan_id_o(chan_id_o), .chan_write_o(chan_write_o),
    .cpl_valid_i(cpl_valid_i), .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr [NC];
  int          m_cnt [NC];
  bit          m_v   [NC];
  logic [31:0] m_addr[NC];
  logic [8:0]  m_id  [NC];
  bit          m_w   [NC];
  bit          m_gany[NC];
  int          m_gsel[NC];
  logic [NR-1:0] m_ready;

  function automatic int chan_of(input logic [31:0] a);
    return int'(a[11:10]);
  endfunction

  always_comb begin
    int rr;
    rr = 0;
    m_ready = '0;
    for (int c = 0; c < NC; c++) begin
      m_gany[c] = 1'b0;
      m_gsel[c] = 0;
      if ((!m_v[c] || chan_ready_i[c]) &&
          (m_cnt[c] < MAXO || (m_cnt[c] == MAXO && cpl_valid_i[c]))) begin
        for (int k = 0; k < NR; k++) begin
          rr = (m_ptr[c] + k) % NR;
          if (!m_gany[c] && req_valid_i[rr] && chan_of(a_req[rr]) == c) begin
            m_gany[c]   = 1'b1;
            m_gsel[c]   = rr;
            m_ready[rr] = 1'b1;
          end
        end
      end
    end
    if (!rst_ni) m_ready = '0;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NC; c++) begin
        m_ptr[c] <= 0; m_cnt[c] <= 0; m_v[c] <= 1'b0;
        m_addr[c] <= '0; m_id[c] <= '0; m_w[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (m_gany[c]) begin
          m_v[c]    <= 1'b1;
          m_addr[c] <= a_req[m_gsel[c]];
          m_id[c]   <= {3'(m_gsel[c]), id_req[m_gsel[c]]};
          m_w[c]    <= req_write_i[m_gsel[c]];
          m_ptr[c]  <= (m_gsel[c] + 1) % NR;
        end else if (chan_ready_i[c]) begin
          m_v[c] <= 1'b0;
        end
        m_cnt[c] <= m_cnt[c] + (m_gany[c] ? 1 : 0) - ((cpl_valid_i[c] && m_cnt[c] > 0) ? 1 : 0);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk_i) begin
    bit eb;
    eb = 1'b0;
    chk("req_ready", req_ready_o, m_ready);
    for (int c = 0; c < NC; c++) begin
      eb = eb | m_v[c] | (m_cnt[c] != 0);
      chk($sformatf("chan_valid[%0d]", c), chan_valid_o[c], m_v[c]);
      chk($sformatf("outstanding[%0d]", c), outstanding_o[c*6 +: 6], m_cnt[c]);
      if (m_v[c]) begin
        chk($sformatf("chan_addr[%0d]", c), chan_addr_o[c*AW +: AW], m_addr[c]);
        chk($sformatf("chan_id[%0d]", c), chan_id_o[c*OW +: OW], m_id[c]);
        chk($sformatf("chan_write[%0d]", c), chan_write_o[c], m_w[c]);
      end
    end
    chk("busy", busy_o, eb);
  end

  // ---------------- stimulus ----------------
  task automatic clr_inputs();
    req_valid_i  = '0;
    req_write_i  = '0;
    chan_ready_i = '0;
    cpl_valid_i  = '0;
    for (int i = 0; i < NR; i++) begin
      a_req[i]  = '0;
      id_req[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int want_rr[6];
    int g;
    int ngr;
    want_rr = '{0, 1, 4, 0, 1, 4};
    clr_inputs();
    repeat (2) @(negedge clk_i);
    chk("reset_valid", chan_valid_o, 4'h0);
    chk("reset_outstanding", outstanding_o, 24'h0);
    chk("reset_busy", busy_o, 1'b0);
    rst_ni = 1'b1;

    // Single request
    @(posedge clk_i); #1;
    req_valid_i[2] = 1'b1; a_req[2] = 32'h8000_0400; id_req[2] = 6'h05;
    @(negedge clk_i);
    chk("single_ready", req_ready_o[2], 1'b1);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    chk("single_valid", chan_valid_o[1], 1'b1);
    chk("single_id", chan_id_o[OW +: OW], 9'h085);
    chk("single_addr", chan_addr_o[AW +: AW], 32'h8000_0400);
    chk("single_cnt", outstanding_o[6 +: 6], 6'd1);

    // Round-robin on channel 0
    do_reset();
    @(posedge clk_i); #1;
    chan_ready_i = '1;
    for (int i = 0; i < NR; i++) a_req[i] = 32'h8000_0000;
    req_valid_i = 5'b10011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      g = -1;
      for (int r = 0; r < NR; r++) if (req_ready_o[r]) g = r;
      chk($sformatf("rr_grant%0d", i), g, want_rr[i]);
    end

    // Parallel channels
    do_reset();
    @(posedge clk_i); #1;
    chan_ready_i = '1;
    a_req[0] = 32'h8000_0000; a_req[1] = 32'h8000_0C00;
    req_valid_i = 5'b00011;
    @(negedge clk_i);
    chk("par_ready", req_ready_o, 5'b00011);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    chk("par_valid", chan_valid_o, 4'b1001);

    // Outstanding limit on channel 2
    do_reset();
    @(posedge clk_i); #1;
    chan_ready_i = '1;
    a_req[0] = 32'h8000_0800; req_valid_i = 5'b00001;
    ngr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (req_ready_o[0]) ngr++;
      else break;
    end
    chk("limit_grants", ngr, 32);
    chk("limit_cnt", outstanding_o[12 +: 6], 6'd32);
    @(posedge clk_i); #1;
    cpl_valid_i[2] = 1'b1;
    @(negedge clk_i);
    chk("limit_cpl_grant", req_ready_o[0], 1'b1);
    @(posedge clk_i); #1;
    cpl_valid_i = '0;
    @(negedge clk_i);
    chk("limit_cnt_after", outstanding_o[12 +: 6], 6'd32);
    chk("limit_ready_after", req_ready_o[0], 1'b0);

    // Backpressure on channel 0
    do_reset();
    @(posedge clk_i); #1;
    a_req[0] = 32'h8000_0010; req_valid_i = 5'b00001;
    @(negedge clk_i);
    chk("bp_first_grant", req_ready_o[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("bp_ready", req_ready_o[0], 1'b0);
      chk("bp_valid", chan_valid_o[0], 1'b1);
      chk("bp_addr", chan_addr_o[0 +: AW], 32'h8000_0010);
    end
    @(posedge clk_i); #1;
    chan_ready_i[0] = 1'b1;
    @(negedge clk_i);
    chk("bp_regrant", req_ready_o[0], 1'b1);

    // Reset mid-operation
    do_reset();
    @(posedge clk_i); #1;
    chan_ready_i = '1;
    a_req[0] = 32'h8000_0000; req_valid_i = 5'b00001;
    repeat (5) @(posedge clk_i);
    #3;
    chk("mid_cnt", outstanding_o[0 +: 6], 6'd5);
    chk("mid_valid", chan_valid_o[0], 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", chan_valid_o, 4'h0);
    chk("mid_rst_cnt", outstanding_o, 24'h0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ready", req_ready_o, 5'b0);
    clr_inputs();
    chan_ready_i = '1;
    a_req[2] = 32'h8000_0400; a_req[4] = 32'h8000_0400;
    req_valid_i = 5'b10100;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_first", req_ready_o, 5'b00100);

    // Random traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk_i); #1;
      for (int r = 0; r < NR; r++) begin
        req_valid_i[r] = ($urandom_range(0, 99) < 60);
        a_req[r]       = $urandom;
        id_req[r]      = 6'($urandom);
        req_write_i[r] = 1'($urandom);
      end
      for (int c = 0; c < NC; c++) begin
        chan_ready_i[c] = ($urandom_range(0, 99) < 70);
        cpl_valid_i[c]  = (m_cnt[c] > 0) && ($urandom_range(0, 99) < 30);
      end
    end
    @(posedge clk_i); #1;
    clr_inputs();
    @(negedge clk_i);
    @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
